// File: rtl/alu_pkg.sv
// Shared types for the serial bit-slice ALU arbiter.
// Op codes, FSM states and the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        OP_XOR = 2'b00,
        OP_NOR = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_serial_arbiter_alu.sv
// 1-bit ALU cell: evaluates one operand bit pair per cycle.
// Purely combinational; the caller walks it across the word.
module alu_serial_arbiter_alu
    import alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  op_e  op,
    output logic y
);

    always_comb begin
        y = 1'b0;
        unique case (1'b1)
            (op == OP_XOR): y = a ^ b;
            (op == OP_NOR): y = ~(a | b);
            (op == OP_OR):  y = a | b;
            (op == OP_AND): y = a & b;
            default:        y = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_arbiter.sv
// Two-requester round-robin front end for a bit-serial ALU.
// One operation in flight; result held until the consumer takes it.
module alu_serial_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    input  logic [1:0]       i_control0,
    input  logic [1:0]       i_control1,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_res,
    output logic             o_res_id,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    op_e             op_q;
    logic            id_q;
    logic            last_q;
    logic            win;
    logic            accept;
    logic            alu_y;

    // Contention goes to whoever was not granted last time.
    assign win = (i_req_valid == 2'b11) ? ~last_q
                                        : i_req_valid[1];

    always_comb begin
        state_d     = state_q;
        o_req_ready = 2'b00;
        accept      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_rst_n && (|i_req_valid)) begin
                    o_req_ready = win ? 2'b10 : 2'b01;
                    accept      = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            op_q   <= OP_XOR;
            id_q   <= 1'b0;
            last_q <= 1'b1;
            cnt    <= '0;
        end else if (accept) begin
            a_q    <= win ? i_a1 : i_a0;
            b_q    <= win ? i_b1 : i_b0;
            op_q   <= op_e'(win ? i_control1 : i_control0);
            id_q   <= win;
            last_q <= win;
            cnt    <= '0;
        end else if (state_q == ST_RUN) begin
            res_q[cnt] <= alu_y;
            if (cnt != LAST) cnt <= cnt + 1'b1;
        end
    end

    alu_serial_arbiter_alu u_alu (
        .a  (a_q[cnt]),
        .b  (b_q[cnt]),
        .op (op_q),
        .y  (alu_y)
    );

    assign o_res_valid = (state_q == ST_DONE);
    assign o_res       = res_q;
    assign o_res_id    = id_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_serial_arbiter.sv
// Directed bench for alu_serial_arbiter (WIDTH = 8).
// Hand-computed results, latency and arbitration order.
module tb_alu_serial_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   c0, c1;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res;
    logic         res_id;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_serial_arbiter #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_a0        (a0),
        .i_b0        (b0),
        .i_a1        (a1),
        .i_b1        (b1),
        .i_control0  (c0),
        .i_control1  (c1),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res       (res),
        .o_res_id    (res_id),
        .o_busy      (busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Drive a request, check the grant, then cross the accept edge.
    task automatic issue(input logic [1:0]   v,
                         input logic [W-1:0] ia0, ib0,
                         input logic [1:0]   ic0,
                         input logic [W-1:0] ia1, ib1,
                         input logic [1:0]   ic1,
                         input logic [1:0]   exp_rdy);
        req_valid = v;
        a0 = ia0; b0 = ib0; c0 = ic0;
        a1 = ia1; b1 = ib1; c1 = ic1;
        #1;
        chk("req_ready", req_ready, exp_rdy);
        @(posedge clk); #1;
    endtask

    // Wait for the result, check it, hold it, then hand it off.
    task automatic collect(input logic [W-1:0] exp_res,
                           input logic         exp_id,
                           input int           hold);
        int lat;
        logic [W-1:0] snap;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, W);
        chk("res", res, exp_res);
        chk("res_id", res_id, exp_id);
        chk("done_rdy", req_ready, 2'b00);
        snap = res;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_res", res, snap);
            chk("hold_vld", res_valid, 1'b1);
            chk("hold_rdy", req_ready, 2'b00);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("post_vld", res_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        rst_n = 1'b0;
        req_valid = 2'b01;
        res_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        c0 = '0; c1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", req_ready, 2'b00);
        chk("rst_vld", res_valid, 1'b0);
        chk("rst_res", res, 8'h00);
        chk("rst_id", res_id, 1'b0);
        chk("rst_busy", busy, 1'b0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // r0 XOR, then r1 NOR
        issue(2'b01, 8'hA5, 8'h0F, 2'b00,
              8'h00, 8'h00, 2'b00, 2'b01);
        chk("busy_run", busy, 1'b1);
        req_valid = 2'b00;
        collect(8'hAA, 1'b0, 0);
        issue(2'b10, 8'h00, 8'h00, 2'b00,
              8'h00, 8'h01, 2'b01, 2'b10);
        req_valid = 2'b00;
        collect(8'hFE, 1'b1, 0);

        // contention: r0 wins, then r1
        issue(2'b11, 8'hF0, 8'hCC, 2'b11,
              8'hF0, 8'hCC, 2'b10, 2'b01);
        collect(8'hC0, 1'b0, 0);
        issue(2'b11, 8'hF0, 8'hCC, 2'b11,
              8'hF0, 8'hCC, 2'b10, 2'b10);
        req_valid = 2'b00;
        collect(8'hFC, 1'b1, 0);

        // stalled result with r1 waiting
        issue(2'b01, 8'h3C, 8'hFF, 2'b00,
              8'h3C, 8'h0F, 2'b11, 2'b01);
        req_valid = 2'b10;
        collect(8'hC3, 1'b0, 5);
        issue(2'b10, 8'h3C, 8'hFF, 2'b00,
              8'h3C, 8'h0F, 2'b11, 2'b10);
        req_valid = 2'b00;
        collect(8'h0C, 1'b1, 0);

        // reset at cnt=3
        issue(2'b01, 8'h12, 8'h34, 2'b10,
              8'h12, 8'h34, 2'b00, 2'b01);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rdy", req_ready, 2'b00);
        chk("mid_vld", res_valid, 1'b0);
        chk("mid_res", res, 8'h00);
        chk("mid_busy", busy, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) req_valid = 2'b00;
            if (k == 2) rst_n = 1'b1;
            if (res_valid) seen = 1'b1;
        end
        chk("no_stale", seen, 1'b0);

        // both held valid: ids 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            issue(2'b11, 8'h12, 8'h34, 2'b10,
                  8'h12, 8'h34, 2'b00,
                  (k % 2 == 0) ? 2'b01 : 2'b10);
            collect((k % 2 == 0) ? 8'h36 : 8'h26,
                    (k % 2 == 1), 0);
        end
        req_valid = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_serial_arbiter.md
ALU_SERIAL_ARBITER -- requirements
Module: alu_serial_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits, legal values 2 to 32.
REQ-002 The block SHALL have port i_clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_req_valid, input, 2 bits: request valid; bit n belongs to requester n.
REQ-005 The block SHALL have port o_req_ready, output, 2 bits: request accept; bit n belongs to requester n.
REQ-006 The block SHALL have ports i_a0 and i_b0, input, WIDTH bits each: requester 0 operands.
REQ-007 The block SHALL have ports i_a1 and i_b1, input, WIDTH bits each: requester 1 operands.
REQ-008 The block SHALL have ports i_control0 and i_control1, input, 2 bits each: per-requester op code.
REQ-009 The block SHALL have port o_res_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port i_res_ready, input, 1 bit: result consumer accept.
REQ-011 The block SHALL have port o_res, output, WIDTH bits: result word.
REQ-012 The block SHALL have port o_res_id, output, 1 bit: index of the requester that owns o_res.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 Op codes SHALL be bitwise: 00 XOR, 01 NOR, 10 OR, 11 AND.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE, o_req_ready SHALL be driven combinationally, with at most one bit high, and only for a requester whose valid is high.
REQ-017 Arbitration SHALL be round-robin: with both requesters valid, the requester not granted last wins; with one valid, that requester wins.
REQ-018 A handshake (valid and ready both high at a clock edge) SHALL capture operands, op and id, clear the bit counter, and move the FSM to RUN.
REQ-019 o_req_ready SHALL be 0 in RUN and DONE.
REQ-020 Input changes after a handshake SHALL NOT affect the in-flight result.
REQ-021 A requester deasserting valid without a handshake SHALL be legal and SHALL have no effect.
REQ-022 In RUN, each cycle SHALL do three things:
- drive captured bit[cnt] of A and B to the 1-bit ALU;
- store the ALU output into result bit[cnt];
- increment cnt.
REQ-023 The FSM SHALL move from RUN to DONE on the edge that writes bit WIDTH-1, so RUN lasts exactly WIDTH cycles and cnt never exceeds WIDTH-1.
REQ-024 o_res_valid SHALL rise WIDTH cycles after the accepting edge.
REQ-025 In DONE, o_res_valid SHALL be 1, and o_res and o_res_id SHALL be held stable until i_res_ready is high at a clock edge.
REQ-026 When i_res_ready is high at a clock edge in DONE, the FSM SHALL return to IDLE.
REQ-027 No new request SHALL be accepted in the DONE cycle, even when the result handshake occurs in that same cycle; minimum spacing between accepts SHALL be WIDTH+2 cycles.
REQ-028 The counter SHALL be $clog2(WIDTH) bits wide.

Reset
REQ-029 While i_rst_n is low, all outputs SHALL be 0, the FSM SHALL be in IDLE, and cnt and the result register SHALL be 0.
REQ-030 Reset SHALL set the last-grant pointer to 1, so requester 0 wins the first contention.
REQ-031 Reset asserted during RUN or DONE SHALL abandon the operation; that result SHALL never be issued.

Structure
REQ-032 Package alu_pkg SHALL hold the op-code enum, the state enum and the default WIDTH constant.
REQ-033 The block SHALL contain exactly one sub-module: a single instance of the team's existing 1-bit alu cell, which performs all op evaluation.

Verification
REQ-034 After reset, requester 0 sends a=0xA5, b=0x0F, op=00 -> o_req_ready=01 in the same cycle; o_res=0xAA, o_res_id=0, o_res_valid rises 8 cycles after accept.
REQ-035 Both requesters valid in the same cycle: r0 sends a=0xF0, b=0xCC, op=11; r1 sends the same operands with op=10 -> r0 served first with o_res=0xC0, then r1 with o_res=0xFC.
REQ-036 a=0x00, b=0x01, op=01 -> o_res=0xFE.
REQ-037 i_res_ready held 0 for 5 cycles in DONE while r1 is valid -> o_res stays stable, o_req_ready stays 00, and r1 is accepted 1 cycle after the result handshake.
REQ-038 Reset asserted at cnt=3 in RUN -> all outputs 0 at once and no o_res_valid; the next request then completes correctly.
REQ-039 Both requesters held valid for 4 operations -> o_res_id sequence is 0, 1, 0, 1.
